// File: rtl/edge_irq_scheduler.sv
// Edge-capture and interrupt scheduler for the debounced GPIO inputs.
// Captures per-line edges, serves the CPU register window (CAPTURE/MASK/MODE/STATUS)
// and hands one pending, unmasked source at a time to the CPU, round-robin.
module edge_irq_scheduler #(
    parameter int NUM_INPUTS = 12,
    parameter int ID_W       = $clog2(NUM_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [NUM_INPUTS-1:0] noise_canc,
    input  logic                  we,
    input  logic                  re,
    input  logic [1:0]            register_addr,
    input  logic [NUM_INPUTS-1:0] wr_data,
    output logic [NUM_INPUTS-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  irq,
    output logic [ID_W-1:0]       irq_id,
    input  logic                  irq_ack,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SERVE    = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    localparam logic [1:0] A_CAPTURE = 2'd0;
    localparam logic [1:0] A_MASK    = 2'd1;
    localparam logic [1:0] A_MODE    = 2'd2;
    localparam logic [1:0] A_STATUS  = 2'd3;

    logic [NUM_INPUTS-1:0] prev;
    logic [NUM_INPUTS-1:0] capture;
    logic [NUM_INPUTS-1:0] mask;
    logic [NUM_INPUTS-1:0] mode;
    logic [NUM_INPUTS-1:0] evt;
    logic [NUM_INPUTS-1:0] clr;
    logic [NUM_INPUTS-1:0] pending;
    logic [NUM_INPUTS-1:0] status;
    logic [NUM_INPUTS-1:0] rd_mux;
    logic [ID_W-1:0]       last_id;
    logic [ID_W:0]         pick;

    state_t                state, state_nx;
    logic                  irq_nx;
    logic [ID_W-1:0]       irq_id_nx;
    logic [ID_W-1:0]       last_id_nx;

    // Per-line edge event; MODE selects falling over rising, and a frozen block sees no edges.
    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        assign evt[i] = enable & (mode[i] ? (prev[i] & ~noise_canc[i])
                                          : (noise_canc[i] & ~prev[i]));
    end

    assign clr     = (we && register_addr == A_CAPTURE) ? wr_data : '0;
    assign pending = capture & mask;
    assign status  = NUM_INPUTS'({irq_id, state});

    // First requesting line strictly after 'last', wrapping; MSB of the result flags a hit.
    // The scan runs from farthest to nearest so the nearest hit is the one left standing.
    function automatic logic [ID_W:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                              input logic [ID_W-1:0]       last);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] sel;
        int              idx;
        res = '0;
        for (int k = NUM_INPUTS; k >= 1; k--) begin
            idx = int'(last) + k;
            if (idx >= NUM_INPUTS) idx -= NUM_INPUTS;
            sel = ID_W'(idx);
            if (req[sel]) res = {1'b1, sel};
        end
        return res;
    endfunction

    assign pick = rr_pick(pending, last_id);

    // Edge history and capture; a new edge wins over a same-cycle W1C of that bit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev    <= '0;
            capture <= '0;
        end else begin
            if (enable) prev <= noise_canc;
            capture <= (capture & ~clr) | evt;
        end
    end

    // Plain RW configuration registers; writes ignore enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask <= '0;
            mode <= '0;
        end else if (we) begin
            if (register_addr == A_MASK) mask <= wr_data;
            if (register_addr == A_MODE) mode <= wr_data;
        end
    end

    // Read mux sees the registers before any same-cycle write lands.
    always_comb begin
        rd_mux = '0;
        case (register_addr)
            A_CAPTURE: rd_mux = capture;
            A_MASK:    rd_mux = mask;
            A_MODE:    rd_mux = mode;
            A_STATUS:  rd_mux = status;
            default:   rd_mux = '0;
        endcase
    end

    // Registered read port and W1C completion pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            rd_valid <= re;
            if (re) rd_data <= rd_mux;
            done     <= we && (register_addr == A_CAPTURE);
        end
    end

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            irq     <= 1'b0;
            irq_id  <= '0;
            last_id <= '0;
        end else begin
            state   <= state_nx;
            irq     <= irq_nx;
            irq_id  <= irq_id_nx;
            last_id <= last_id_nx;
        end
    end

    // Scheduler next state: pick, serve until ack (or mask withdrawal), then wait for the clear.
    always_comb begin
        state_nx   = state;
        irq_nx     = irq;
        irq_id_nx  = irq_id;
        last_id_nx = last_id;
        if (enable) begin
            case (state)
                IDLE: begin
                    if (pick[ID_W]) begin
                        irq_id_nx = pick[ID_W-1:0];
                        irq_nx    = 1'b1;
                        state_nx  = SERVE;
                    end
                end
                SERVE: begin
                    // Withdrawal takes precedence over a coincident ack.
                    if (!mask[irq_id]) begin
                        irq_nx   = 1'b0;
                        state_nx = IDLE;
                    end else if (irq_ack) begin
                        irq_nx   = 1'b0;
                        state_nx = WAIT_CLR;
                    end
                end
                WAIT_CLR: begin
                    if (!capture[irq_id] || !mask[irq_id]) begin
                        last_id_nx = irq_id;
                        state_nx   = IDLE;
                    end
                end
                default: begin
                    irq_nx   = 1'b0;
                    state_nx = IDLE;
                end
            endcase
        end
    end

endmodule
